// File: rtl/fp_add_arbiter_pkg.sv
// Shared constants for the FP adder arbiter: data width, default tag sizing and
// IEEE-754 single-precision values used by benches.
package fp_add_arbiter_pkg;

    localparam int unsigned FP_W          = 32;
    localparam int unsigned DEF_TAG_DEPTH = 8;
    localparam int unsigned DEF_TAG_W     = 3;

    localparam logic [31:0] POS_ONE = 32'h3F80_0000;
    localparam logic [31:0] POS_TWO = 32'h4000_0000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/fp_arb_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each op in flight through
// the adder; head tag is visible combinationally on pop_tag.
module fp_arb_tag_fifo
    import fp_add_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W     = DEF_TAG_W,
    parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [TAG_W-1:0]               push_tag,
    input  logic                           pop,
    output logic [TAG_W-1:0]               pop_tag,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(TAG_DEPTH+1)-1:0] count
);
    localparam int unsigned AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

    logic [TAG_W-1:0] mem [TAG_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_tag = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front end sharing one fixed-latency FP adder among NUM_REQ clients.
// Define FP_ARB_STATS_EN to build the 32-bit issued-op counter on opCountOut.
module fp_add_arbiter
    import fp_add_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH,
    parameter int unsigned TAG_W     = DEF_TAG_W
) (
    input  logic                    clkIn,
    input  logic                    rstIn,
    input  logic [NUM_REQ-1:0]      reqValidIn,
    input  logic [NUM_REQ*FP_W-1:0] reqDataAIn,
    input  logic [NUM_REQ*FP_W-1:0] reqDataBIn,
    output logic [NUM_REQ-1:0]      reqReadyOut,
    output logic [NUM_REQ-1:0]      respValidOut,
    output logic [FP_W-1:0]         respDataOut,
    output logic [FP_W-1:0]         addDataAOut,
    output logic [FP_W-1:0]         addDataBOut,
    output logic                    addValidOut,
    input  logic [FP_W-1:0]         addDataIn,
    input  logic                    addValidIn,
    output logic                    errOut,
    output logic [31:0]             opCountOut
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;
    logic               tag_full;
    logic               tag_empty;
    logic [TAG_W-1:0]   pop_tag;
    logic [CW-1:0]      in_flight;
    logic               pop;

    // Grant only goes to a valid requester, so a grant is always a handshake.
    always_comb begin
        logic [IW:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        if (!rstIn && !tag_full) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, rr_ptr} + (IW+1)'(k);
                if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
                if (!grant_any && reqValidIn[idx[IW-1:0]]) begin
                    grant[idx[IW-1:0]] = 1'b1;
                    grant_idx          = idx[IW-1:0];
                    grant_any          = 1'b1;
                end
            end
        end
    end

    assign reqReadyOut = grant;
    assign pop         = addValidIn & ~tag_empty;

    fp_arb_tag_fifo #(
        .TAG_W     (TAG_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clkIn),
        .rst      (rstIn),
        .push     (grant_any),
        .push_tag (TAG_W'(grant_idx)),
        .pop      (pop),
        .pop_tag  (pop_tag),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (in_flight)
    );

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            rr_ptr       <= '0;
            addValidOut  <= 1'b0;
            addDataAOut  <= '0;
            addDataBOut  <= '0;
            respValidOut <= '0;
            respDataOut  <= '0;
            errOut       <= 1'b0;
        end else begin
            addValidOut <= grant_any;
            if (grant_any) begin
                addDataAOut <= reqDataAIn[FP_W*grant_idx +: FP_W];
                addDataBOut <= reqDataBIn[FP_W*grant_idx +: FP_W];
                rr_ptr      <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            respValidOut <= pop ? (NUM_REQ'(1) << pop_tag) : '0;
            if (pop) respDataOut <= addDataIn;
            // A result with nothing in flight is dropped and latched as an error.
            if (addValidIn && (in_flight == '0)) errOut <= 1'b1;
        end
    end

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clkIn) begin
        if (rstIn) opCountOut <= '0;
        else if (grant_any) opCountOut <= opCountOut + 1'b1;
    end
`else
    assign opCountOut = '0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: behavioural queue model compared every
// cycle, a fixed-latency adder model, and directed tests with literal expectations.
module tb_fp_add_arbiter;
    import fp_add_arbiter_pkg::*;

    localparam int NR  = 4;
    localparam int TD  = 8;
    localparam int TW  = 3;
    localparam int LAT = 3;

    localparam logic [31:0] THREE = 32'h4040_0000;
    localparam logic [31:0] FOUR  = 32'h4080_0000;
    localparam logic [31:0] FIVE  = 32'h40A0_0000;
    localparam logic [31:0] SIX   = 32'h40C0_0000;

`ifdef FP_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clkIn = 1'b0;
    logic            rstIn = 1'b1;
    logic [NR-1:0]   reqValidIn;
    logic [NR*32-1:0] reqDataAIn;
    logic [NR*32-1:0] reqDataBIn;
    logic [NR-1:0]   reqReadyOut;
    logic [NR-1:0]   respValidOut;
    logic [31:0]     respDataOut;
    logic [31:0]     addDataAOut;
    logic [31:0]     addDataBOut;
    logic            addValidOut;
    logic [31:0]     addDataIn;
    logic            addValidIn;
    logic            errOut;
    logic [31:0]     opCountOut;

    fp_add_arbiter #(
        .NUM_REQ   (NR),
        .TAG_DEPTH (TD),
        .TAG_W     (TW)
    ) dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .reqValidIn   (reqValidIn),
        .reqDataAIn   (reqDataAIn),
        .reqDataBIn   (reqDataBIn),
        .reqReadyOut  (reqReadyOut),
        .respValidOut (respValidOut),
        .respDataOut  (respDataOut),
        .addDataAOut  (addDataAOut),
        .addDataBOut  (addDataBOut),
        .addValidOut  (addValidOut),
        .addDataIn    (addDataIn),
        .addValidIn   (addValidIn),
        .errOut       (errOut),
        .opCountOut   (opCountOut)
    );

    always #5 clkIn = ~clkIn;

    int unsigned cyc = 0;
    always @(posedge clkIn) cyc++;

    int compared   = 0;
    int mismatched = 0;

    typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct { logic [31:0] sum; int unsigned due; } res_t;
    typedef struct { int idx; int unsigned cyc; } glog_t;
    typedef struct { int idx; logic [31:0] data; int unsigned cyc; } rlog_t;

    op_t         rq [NR][$];
    res_t        aq [$];
    glog_t       grant_log [$];
    int unsigned iss_log [$];
    rlog_t       resp_log [$];
    logic [NR-1:0] took = '0;
    bit          stall = 1'b0;
    bit          inj   = 1'b0;
    int          credit = 0;

    // Model state: in-flight owners as a plain queue, pointer as an integer.
    int          m_q [$];
    int          m_rr = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_cnt = '0;
    logic        p_av = 1'b0;
    logic [31:0] p_a = '0, p_b = '0, p_rd = '0;
    logic [NR-1:0] p_rv = '0;

    function automatic real fp_to_real(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp(fp_to_real(a) + fp_to_real(b));
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requester drivers and adder model, just after each falling edge.
    always @(negedge clkIn) begin
        #1;
        for (int i = 0; i < NR; i++)
            if (took[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        took = '0;
        for (int i = 0; i < NR; i++) begin
            if (!rstIn && rq[i].size() > 0) begin
                reqValidIn[i]          = 1'b1;
                reqDataAIn[32*i +: 32] = rq[i][0].a;
                reqDataBIn[32*i +: 32] = rq[i][0].b;
            end else begin
                reqValidIn[i] = 1'b0;
            end
        end
        if (rstIn) aq.delete();
        else if (addValidOut) aq.push_back('{fp32_add(addDataAOut, addDataBOut), cyc + LAT + 1});
        addValidIn = 1'b0;
        if (inj) begin
            addValidIn = 1'b1;
            addDataIn  = QNAN;
            inj        = 1'b0;
        end else if (aq.size() > 0 && aq[0].due <= cyc + 1 && (!stall || credit > 0)) begin
            res_t r;
            r          = aq.pop_front();
            addValidIn = 1'b1;
            addDataIn  = r.sum;
            if (stall) credit--;
        end
    end

    task automatic phase_a();
        logic [NR-1:0] exp_g;
        int g;
        exp_g = '0;
        g     = -1;
        if (rstIn) begin
            m_q.delete();
            m_rr = 0; m_err = 1'b0; m_cnt = '0;
            p_av = 1'b0; p_a = '0; p_b = '0; p_rv = '0; p_rd = '0;
        end else begin
            if (m_q.size() < TD)
                for (int k = 0; k < NR; k++)
                    if (g < 0 && reqValidIn[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            if (g >= 0) exp_g[g] = 1'b1;
            p_av = (g >= 0);
            if (g >= 0) begin
                p_a = reqDataAIn[32*g +: 32];
                p_b = reqDataBIn[32*g +: 32];
            end
            p_rv = '0;
            if (addValidIn) begin
                if (m_q.size() == 0) m_err = 1'b1;
                else begin
                    p_rv = NR'(1) << m_q.pop_front();
                    p_rd = addDataIn;
                end
            end
            if (g >= 0) begin
                m_q.push_back(g);
                m_rr = (g + 1) % NR;
                if (STATS) m_cnt++;
            end
        end
        chk("grant", 32'(reqReadyOut), 32'(exp_g));
        took = reqValidIn & reqReadyOut;
        if (|took) grant_log.push_back('{onehot_idx(reqReadyOut), cyc});
    endtask

    task automatic phase_b();
        chk("addValidOut", 32'(addValidOut), 32'(p_av));
        chk("addDataAOut", addDataAOut, p_a);
        chk("addDataBOut", addDataBOut, p_b);
        chk("respValidOut", 32'(respValidOut), 32'(p_rv));
        chk("respDataOut", respDataOut, p_rd);
        chk("errOut", 32'(errOut), 32'(m_err));
        chk("opCountOut", opCountOut, m_cnt);
        if (addValidOut) iss_log.push_back(cyc);
        if (|respValidOut) resp_log.push_back('{onehot_idx(respValidOut), respDataOut, cyc});
    endtask

    initial begin
        forever begin
            @(negedge clkIn);
            #4 phase_a();
            @(posedge clkIn);
            #1 phase_b();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        grant_log.delete();
        iss_log.delete();
        resp_log.delete();
    endtask

    task automatic reset_dut();
        rstIn = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        stall  = 1'b0;
        credit = 0;
        repeat (2) @(negedge clkIn);
        rstIn = 1'b0;
    endtask

    task automatic wait_resp(input string nm, input int n, input int budget);
        int b = 0;
        while (resp_log.size() < n && b < budget) begin
            @(negedge clkIn);
            b++;
        end
        chk(nm, 32'(resp_log.size() >= n), 32'd1);
    endtask

    task automatic wait_grants(input string nm, input int n, input int budget);
        int b = 0;
        while (grant_log.size() < n && b < budget) begin
            @(negedge clkIn);
            b++;
        end
        chk(nm, 32'(grant_log.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int b = 0;
        bit busy = 1'b1;
        while (busy && b < budget) begin
            busy = (m_q.size() > 0) || (aq.size() > 0);
            for (int i = 0; i < NR; i++) if (rq[i].size() > 0) busy = 1'b1;
            if (busy) begin
                @(negedge clkIn);
                b++;
            end
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_data [5];
        int          exp_idx  [5];
        reqValidIn = '0;
        reqDataAIn = '0;
        reqDataBIn = '0;
        addValidIn = 1'b0;
        addDataIn  = '0;
        @(negedge clkIn);
        reset_dut();

        // Reset state
        #4;
        chk("rst_addValidOut", 32'(addValidOut), 32'd0);
        chk("rst_respValidOut", 32'(respValidOut), 32'd0);
        chk("rst_errOut", 32'(errOut), 32'd0);
        chk("rst_reqReadyOut", 32'(reqReadyOut), 32'd0);
        chk("rst_opCountOut", opCountOut, 32'd0);

        // 1: single op 1.0 + 1.0 from requester 0
        @(negedge clkIn);
        clear_logs();
        rq[0].push_back('{POS_ONE, POS_ONE});
        wait_resp("t1_resp_seen", 1, 40);
        if (resp_log.size() >= 1 && iss_log.size() >= 1 && grant_log.size() >= 1) begin
            chk("t1_resp_idx", 32'(resp_log[0].idx), 32'd0);
            chk("t1_resp_data", resp_log[0].data, POS_TWO);
            chk("t1_issue_delay", iss_log[0] - grant_log[0].cyc, 32'd1);
            chk("t1_result_delay", resp_log[0].cyc - iss_log[0], 32'(LAT + 1));
        end
        wait_idle("t1_idle", 40);

        // 2: contention, all four valid together, requester 0 holds a second op
        reset_dut();
        clear_logs();
        rq[0].push_back('{POS_ONE, POS_ONE});
        rq[0].push_back('{FIVE, POS_ONE});
        rq[1].push_back('{POS_TWO, POS_ONE});
        rq[2].push_back('{THREE, POS_ONE});
        rq[3].push_back('{FOUR, POS_ONE});
        exp_idx  = '{0, 1, 2, 3, 0};
        exp_data = '{POS_TWO, THREE, FOUR, FIVE, SIX};
        wait_resp("t2_resp_seen", 5, 60);
        for (int i = 0; i < 5; i++) begin
            if (grant_log.size() > i) begin
                chk($sformatf("t2_grant_idx%0d", i), 32'(grant_log[i].idx), 32'(exp_idx[i]));
                chk($sformatf("t2_grant_cyc%0d", i), grant_log[i].cyc - grant_log[0].cyc, 32'(i));
            end
            if (resp_log.size() > i) begin
                chk($sformatf("t2_resp_idx%0d", i), 32'(resp_log[i].idx), 32'(exp_idx[i]));
                chk($sformatf("t2_resp_data%0d", i), resp_log[i].data, exp_data[i]);
            end
        end
        wait_idle("t2_idle", 60);

        // 3: stalled adder fills all tags; one pop frees a slot next cycle
        reset_dut();
        clear_logs();
        stall = 1'b1;
        for (int i = 0; i < TD + 1; i++) rq[0].push_back('{POS_ONE, POS_ONE});
        wait_grants("t3_fill", TD, 30);
        #4;
        chk("t3_full_ready", 32'(reqReadyOut), 32'd0);
        chk("t3_full_count", 32'(grant_log.size()), 32'(TD));
        @(negedge clkIn);
        #4 chk("t3_full_ready_hold", 32'(reqReadyOut), 32'd0);
        @(negedge clkIn);
        credit = 1;
        #4 chk("t3_pop_cycle_ready", 32'(reqReadyOut), 32'd0);
        @(negedge clkIn);
        #4 chk("t3_resume_ready", 32'(reqReadyOut), 32'b0001);
        @(negedge clkIn);
        stall = 1'b0;
        wait_resp("t3_drain", TD + 1, 60);
        wait_idle("t3_idle", 60);
        chk("t3_total_grants", 32'(grant_log.size()), 32'(TD + 1));

        // 4: result with nothing in flight
        clear_logs();
        repeat (2) @(negedge clkIn);
        inj = 1'b1;
        repeat (2) @(negedge clkIn);
        for (int i = 0; i < 4; i++) begin
            #4;
            chk("t4_err_sticky", 32'(errOut), 32'd1);
            chk("t4_no_resp", 32'(respValidOut), 32'd0);
            @(negedge clkIn);
        end
        chk("t4_resp_log_empty", 32'(resp_log.size()), 32'd0);

        // 5: reset with three ops in flight
        reset_dut();
        clear_logs();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) rq[2].push_back('{THREE, THREE});
        wait_grants("t5_fill", 3, 20);
        @(negedge clkIn);
        rstIn = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        stall = 1'b0;
        @(posedge clkIn);
        #1;
        chk("t5_rst_addValidOut", 32'(addValidOut), 32'd0);
        chk("t5_rst_addDataAOut", addDataAOut, 32'd0);
        chk("t5_rst_respValidOut", 32'(respValidOut), 32'd0);
        chk("t5_rst_respDataOut", respDataOut, 32'd0);
        chk("t5_rst_errOut", 32'(errOut), 32'd0);
        chk("t5_rst_opCountOut", opCountOut, 32'd0);
        chk("t5_rst_ready", 32'(reqReadyOut), 32'd0);
        @(negedge clkIn);
        rstIn = 1'b0;
        rq[1].push_back('{POS_ONE, POS_TWO});
        rq[3].push_back('{POS_TWO, POS_TWO});
        #4 chk("t5_first_grant", 32'(reqReadyOut), 32'b0010);
        wait_idle("t5_idle", 60);

        // 6: issued-op counter after ten issues
        reset_dut();
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            rq[1].push_back('{POS_ONE, POS_ONE});
            rq[3].push_back('{POS_TWO, POS_ONE});
        end
        wait_grants("t6_grants", 10, 60);
        wait_idle("t6_idle", 60);
`ifdef FP_ARB_STATS_EN
        chk("t6_opcount", opCountOut, 32'd10);
`else
        chk("t6_opcount", opCountOut, 32'd0);
`endif

        repeat (2) @(negedge clkIn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
